// File: rtl/array_arbiter_pkg.sv
// Shared types for the two-requester array arbiter: FSM state and grant encoding.
package array_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      OWN_A = 2'd1,
      OWN_B = 2'd2
   } arb_state_t;

   typedef enum logic [1:0] {
      GNT_NONE = 2'd0,
      GNT_A    = 2'd1,
      GNT_B    = 2'd2
   } grant_t;

endpackage

// File: rtl/array_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port array memory.
// Handshake: a command moves when m_valid & m_ready; the requester's ready mirrors m_ready only while it holds the grant.
`ifndef addrN
`define addrN 8
`endif
`ifndef intN
`define intN 8
`endif

module array_arbiter
   import array_arbiter_pkg::*;
#(
   parameter int AN = `addrN,
   parameter int DN = `intN
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [AN-1:0] a_addr,
   input  logic          a_we,
   input  logic [DN-1:0] a_di,
   input  logic          a_valid,
   output logic          a_ready,
   output logic [DN-1:0] a_do,
   input  logic [AN-1:0] b_addr,
   input  logic          b_we,
   input  logic [DN-1:0] b_di,
   input  logic          b_valid,
   output logic          b_ready,
   output logic [DN-1:0] b_do,
   output logic [AN-1:0] m_addr,
   output logic          m_we,
   output logic [DN-1:0] m_di,
   output logic          m_valid,
   input  logic          m_ready,
   input  logic [DN-1:0] m_do,
   output logic [1:0]    state_dbg
);

   arb_state_t state, state_nx;
   grant_t     grant;
   logic       last_grant;
   logic       xfer_done;

   // Grant decision: an owner keeps the grant while it stays valid; IDLE picks
   // the single valid requester, or the one not served last when both are valid.
   always_comb begin
      grant = GNT_NONE;
      if (!rst) begin
         unique case (state)
            IDLE: begin
               if (a_valid && b_valid) grant = last_grant ? GNT_A : GNT_B;
               else if (a_valid)       grant = GNT_A;
               else if (b_valid)       grant = GNT_B;
            end
            OWN_A:   if (a_valid) grant = GNT_A;
            OWN_B:   if (b_valid) grant = GNT_B;
            default: grant = GNT_NONE;
         endcase
      end
   end

   always_comb begin
      m_valid = 1'b0;
      m_we    = 1'b0;
      m_addr  = '0;
      m_di    = '0;
      a_ready = 1'b0;
      b_ready = 1'b0;
      unique case (grant)
         GNT_A: begin
            m_valid = 1'b1;
            m_we    = a_we;
            m_addr  = a_addr;
            m_di    = a_di;
            a_ready = m_ready;
         end
         GNT_B: begin
            m_valid = 1'b1;
            m_we    = b_we;
            m_addr  = b_addr;
            m_di    = b_di;
            b_ready = m_ready;
         end
         default: ;
      endcase
   end

   assign xfer_done = m_valid & m_ready;

   // A stalled grant is held in OWN_x; completion or a dropped valid returns to IDLE.
   always_comb begin
      state_nx = IDLE;
      if (grant == GNT_A && !xfer_done) state_nx = OWN_A;
      else if (grant == GNT_B && !xfer_done) state_nx = OWN_B;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         last_grant <= 1'b1;
         a_do       <= '0;
         b_do       <= '0;
      end else begin
         state <= state_nx;
         if (xfer_done) begin
            last_grant <= (grant == GNT_B);
            if (grant == GNT_A) a_do <= m_do;
            else                b_do <= m_do;
         end
      end
   end

   assign state_dbg = state;

endmodule

// File: tb/tb_array_arbiter.sv
// Directed bench for array_arbiter with a cycle-level reference model and a grant-order scoreboard.
module tb_array_arbiter;
  import array_arbiter_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] a_addr, b_addr, m_addr;
  logic       a_we, b_we, m_we;
  logic [7:0] a_di, b_di, m_di;
  logic       a_valid, b_valid, m_valid;
  logic       a_ready, b_ready, m_ready;
  logic [7:0] a_do, b_do, m_do;
  logic [1:0] state_dbg;

  int chk_cnt = 0;
  int pass_cnt = 0;

  logic [7:0] mem [256];
  logic [7:0] exp_mem [256];
  logic [1:0] grant_log [$];
  logic [1:0] exp_q [$];

  int         md_owner;   // 0 none, 1 A, 2 B: requester holding a stalled grant
  logic       md_last;    // 1 means B was served most recently
  logic [7:0] md_ado, md_bdo;

  array_arbiter #(.AN(8), .DN(8)) dut (
    .clk(clk), .rst(rst),
    .a_addr(a_addr), .a_we(a_we), .a_di(a_di), .a_valid(a_valid), .a_ready(a_ready), .a_do(a_do),
    .b_addr(b_addr), .b_we(b_we), .b_di(b_di), .b_valid(b_valid), .b_ready(b_ready), .b_do(b_do),
    .m_addr(m_addr), .m_we(m_we), .m_di(m_di), .m_valid(m_valid), .m_ready(m_ready), .m_do(m_do),
    .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  // downstream array stub: combinational read, write on accepted command
  assign m_do = mem[m_addr];
  always @(posedge clk) begin
    if (m_valid && m_ready && m_we) mem[m_addr] <= m_di;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // compare process: model decides who must be served this cycle
  always @(negedge clk) begin
    int g;
    logic [7:0] e_addr, e_di, rdata;
    logic e_we;
    if (rst) g = 0;
    else if (md_owner != 0) g = (md_owner == 1) ? (a_valid ? 1 : 0) : (b_valid ? 2 : 0);
    else if (a_valid && b_valid) g = md_last ? 1 : 2;
    else if (a_valid) g = 1;
    else if (b_valid) g = 2;
    else g = 0;
    e_addr = (g == 1) ? a_addr : (g == 2) ? b_addr : 8'd0;
    e_di   = (g == 1) ? a_di   : (g == 2) ? b_di   : 8'd0;
    e_we   = (g == 1) ? a_we   : (g == 2) ? b_we   : 1'b0;
    chk("m_valid", m_valid, g != 0);
    chk("m_addr", m_addr, e_addr);
    chk("m_we", m_we, e_we);
    chk("m_di", m_di, e_di);
    chk("a_ready", a_ready, (g == 1) && m_ready);
    chk("b_ready", b_ready, (g == 2) && m_ready);
    chk("ready_excl", a_ready & b_ready, 0);
    chk("a_do", a_do, md_ado);
    chk("b_do", b_do, md_bdo);
    chk("state", state_dbg, (md_owner == 1) ? OWN_A : (md_owner == 2) ? OWN_B : IDLE);
    if (rst) begin
      md_owner = 0; md_last = 1'b1; md_ado = 8'd0; md_bdo = 8'd0;
    end else if (g != 0 && m_ready) begin
      rdata = exp_mem[e_addr];
      if (g == 1) md_ado = rdata; else md_bdo = rdata;
      if (e_we) exp_mem[e_addr] = e_di;
      md_last = (g == 2);
      md_owner = 0;
      grant_log.push_back(2'(g));
    end else begin
      md_owner = g;
    end
  end

  // driver tasks
  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic drive_a(input logic v, input logic [7:0] addr, input logic we, input logic [7:0] di);
    a_valid = v; a_addr = addr; a_we = we; a_di = di;
  endtask

  task automatic drive_b(input logic v, input logic [7:0] addr, input logic we, input logic [7:0] di);
    b_valid = v; b_addr = addr; b_we = we; b_di = di;
  endtask

  task automatic idle_all();
    drive_a(0, 0, 0, 0); drive_b(0, 0, 0, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1; idle_all();
    cyc(); cyc();
    rst = 1'b0;
  endtask

  task automatic check_log(input string name);
    chk({name, "_len"}, grant_log.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      if (i < grant_log.size()) chk(name, grant_log[i], exp_q[i]);
    grant_log.delete();
    exp_q.delete();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i] = 8'(i + 100);
      exp_mem[i] = 8'(i + 100);
    end
    mem[3] = 8'd42; exp_mem[3] = 8'd42;
    mem[5] = 8'd7;  exp_mem[5] = 8'd7;
    md_owner = 0; md_last = 1'b1; md_ado = 8'd0; md_bdo = 8'd0;
    m_ready = 1'b0;
    do_reset();
    settle();
    chk("rst_a_do", a_do, 0);
    chk("rst_b_do", b_do, 0);
    cyc();

    // only A reads addr 3
    drive_a(1, 3, 0, 0); m_ready = 1'b1;
    settle();
    chk("t1_m_valid", m_valid, 1);
    chk("t1_m_addr", m_addr, 3);
    chk("t1_b_ready", b_ready, 0);
    cyc(); idle_all(); settle();
    chk("t1_a_do", a_do, 42);
    cyc();

    // both valid straight out of reset: A first, then B
    do_reset();
    drive_a(1, 3, 0, 0); drive_b(1, 5, 0, 0); m_ready = 1'b1;
    settle();
    chk("t2_a_ready", a_ready, 1);
    chk("t2_m_addr_a", m_addr, 3);
    cyc(); drive_a(0, 0, 0, 0); settle();
    chk("t2_b_ready", b_ready, 1);
    chk("t2_m_addr_b", m_addr, 5);
    chk("t2_a_do", a_do, 42);
    cyc(); idle_all(); settle();
    chk("t2_b_do", b_do, 7);
    grant_log.delete();
    cyc();

    // both held valid for 6 cycles: strict alternation
    drive_a(1, 3, 0, 0); drive_b(1, 5, 0, 0);
    for (int i = 0; i < 6; i++) cyc();
    idle_all();
    exp_q = '{2'd1, 2'd2, 2'd1, 2'd2, 2'd1, 2'd2};
    check_log("t3_order");

    // A stalls 3 cycles with B waiting; grant and command stay put
    drive_a(1, 3, 0, 0); drive_b(1, 5, 0, 0); m_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("t4_m_addr", m_addr, 3);
      chk("t4_b_ready", b_ready, 0);
      cyc();
    end
    m_ready = 1'b1;
    cyc(); drive_a(0, 0, 0, 0);
    cyc(); idle_all();
    cyc();
    exp_q = '{2'd1, 2'd2};
    check_log("t4_order");

    // back-to-back reads from A alone
    for (int i = 1; i <= 4; i++) begin
      drive_a(1, 8'(i), 0, 0);
      cyc();
    end
    idle_all(); settle();
    chk("t5_a_do", a_do, 104);
    cyc();
    exp_q = '{2'd1, 2'd1, 2'd1, 2'd1};
    check_log("t5_order");

    // B writes 99 to addr 3, then A reads it back
    drive_b(1, 3, 1, 99); settle();
    chk("t6_m_we", m_we, 1);
    chk("t6_m_di", m_di, 99);
    cyc(); drive_b(0, 0, 0, 0); drive_a(1, 3, 0, 0); settle();
    chk("t6_b_do", b_do, 42);
    cyc(); idle_all(); settle();
    chk("t6_a_do", a_do, 99);
    cyc();

    // A drops valid mid-stall: back to IDLE, nothing updated
    drive_a(1, 9, 0, 0); m_ready = 1'b0;
    cyc(); drive_a(0, 0, 0, 0);
    cyc(); settle();
    chk("t7_state", state_dbg, IDLE);
    chk("t7_a_do", a_do, 99);
    cyc();
    drive_a(1, 3, 0, 0); drive_b(1, 5, 0, 0); m_ready = 1'b1; settle();
    chk("t7_b_ready", b_ready, 1);
    cyc(); idle_all();
    cyc();

    // reset during an OWN_B stall
    drive_b(1, 5, 0, 0); m_ready = 1'b0;
    cyc(); settle();
    chk("t8_own_b", state_dbg, OWN_B);
    rst = 1'b1; #1;
    chk("t8_rst_m_valid", m_valid, 0);
    chk("t8_rst_b_ready", b_ready, 0);
    cyc(); rst = 1'b0; idle_all(); settle();
    chk("t8_state", state_dbg, IDLE);
    chk("t8_a_do", a_do, 0);
    chk("t8_b_do", b_do, 0);
    chk("t8_m_valid", m_valid, 0);
    cyc();
    drive_a(1, 3, 0, 0); drive_b(1, 5, 0, 0); m_ready = 1'b1; settle();
    chk("t8_a_first", a_ready, 1);
    chk("t8_m_addr", m_addr, 3);
    cyc(); idle_all();
    cyc(); cyc();

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
